// File: rtl/dmem_pkg.sv
// Shared types and constants for the dual-port data memory.
//   WORD_W / LINE_W / LANES : scalar word, vector line and words-per-line sizes
//   lane_t                  : word position inside a line
//   line_t                  : one 128-bit storage line
//   clr_state_t             : power-up clear sequencer states (used with DMEM_CLEAR_EN)
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned LANES  = 4;

  typedef logic [1:0]        lane_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    RESET_S,
    CLEAR,
    RUN
  } clr_state_t;

endpackage

// File: rtl/dmem_bank.sv
// Line-organised storage array with two write ports and two registered read ports.
//   clk_i, rst_ni            : clock, async active-low reset (read registers only)
//   vec_we_i/_widx_i/_wdata_i: full-line write
//   sc_we_i/_widx_i/_lane_i/_wdata_i : single-word write into one lane of a line
//   sc_ridx_i, vec_ridx_i    : read line indices, sampled every cycle
//   rd_zero_i                : force both read registers to zero this edge
//   sc_rline_o, vec_rline_o  : registered read lines (1-cycle latency)
// Reads observe the array as it looks after this edge's writes (vector first, then scalar
// word on top), which gives write-first and cross-port forwarding in one place.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int unsigned Lines  = 1024,
  parameter int unsigned LineAw = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vec_we_i,
  input  logic [LineAw-1:0] vec_widx_i,
  input  line_t             vec_wdata_i,
  input  logic              sc_we_i,
  input  logic [LineAw-1:0] sc_widx_i,
  input  lane_t             sc_lane_i,
  input  logic [WORD_W-1:0] sc_wdata_i,
  input  logic [LineAw-1:0] sc_ridx_i,
  input  logic [LineAw-1:0] vec_ridx_i,
  input  logic              rd_zero_i,
  output line_t             sc_rline_o,
  output line_t             vec_rline_o
);

  line_t mem_q [Lines];
  line_t sc_view;
  line_t vec_view;
  line_t sc_rline_q;
  line_t vec_rline_q;

  // Scalar write follows the vector write so that it owns its lane on a dual hit.
  always_ff @(posedge clk_i) begin
    if (vec_we_i) begin
      mem_q[vec_widx_i] <= vec_wdata_i;
    end
    if (sc_we_i) begin
      mem_q[sc_widx_i][int'(sc_lane_i)*WORD_W +: WORD_W] <= sc_wdata_i;
    end
  end

  always_comb begin
    sc_view = mem_q[sc_ridx_i];
    if (vec_we_i && (vec_widx_i == sc_ridx_i)) begin
      sc_view = vec_wdata_i;
    end
    if (sc_we_i && (sc_widx_i == sc_ridx_i)) begin
      sc_view[int'(sc_lane_i)*WORD_W +: WORD_W] = sc_wdata_i;
    end

    vec_view = mem_q[vec_ridx_i];
    if (vec_we_i && (vec_widx_i == vec_ridx_i)) begin
      vec_view = vec_wdata_i;
    end
    if (sc_we_i && (sc_widx_i == vec_ridx_i)) begin
      vec_view[int'(sc_lane_i)*WORD_W +: WORD_W] = sc_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sc_rline_q  <= '0;
      vec_rline_q <= '0;
    end else if (rd_zero_i) begin
      sc_rline_q  <= '0;
      vec_rline_q <= '0;
    end else begin
      sc_rline_q  <= sc_view;
      vec_rline_q <= vec_view;
    end
  end

  assign sc_rline_o  = sc_rline_q;
  assign vec_rline_o = vec_rline_q;

endmodule

// File: rtl/dual_data_mem.sv
// Data memory shared by the scalar (32-bit) and vector (128-bit) pipeline ports.
//   clk, reset (async, active-low)
//   MemWriteE, ALUOutE, WriteDataE -> ReadDataM : scalar port, 1-cycle read latency
//   wren_b, address_b, data_b      -> q_b       : vector port, 1-cycle read latency
//   collision    : pulses for one cycle after both ports wrote the same line
//   misalign_cnt : saturating count of misaligned writes (up to two per cycle)
//   busy         : power-up clear in progress
// Optional macro DMEM_CLEAR_EN: builds a clear sequencer that zeroes every line after reset
// release; without it busy is tied low and storage powers up uninitialised.
module dual_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS),
  parameter int unsigned SAT_MAX     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteE,
  input  logic [31:0]       ALUOutE,
  input  logic [31:0]       WriteDataE,
  output logic [31:0]       ReadDataM,
  input  logic              wren_b,
  input  logic [31:0]       address_b,
  input  logic [LINE_W-1:0] data_b,
  output logic [LINE_W-1:0] q_b,
  output logic              collision,
  output logic [7:0]        misalign_cnt,
  output logic              busy
);

  localparam int unsigned LINES   = DEPTH_WORDS / LANES;
  localparam int unsigned LINE_AW = ADDR_W - 2;

  // Address decode; upper bits are dropped so addresses wrap, low bits align down.
  logic [LINE_AW-1:0] sc_line;
  logic [LINE_AW-1:0] vec_line;
  lane_t              sc_lane;
  logic               unused_addr_bits;

  assign sc_line          = ALUOutE[ADDR_W+1:4];
  assign sc_lane          = ALUOutE[3:2];
  assign vec_line         = address_b[ADDR_W+1:4];
  assign unused_addr_bits = ^{ALUOutE[31:ADDR_W+2], address_b[31:ADDR_W+2]};

  logic               wr_ok;
  logic               rd_zero;
  logic               clear_we;
  logic [LINE_AW-1:0] clear_idx;

`ifdef DMEM_CLEAR_EN
  clr_state_t         state_q, state_d;
  logic [LINE_AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_S;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RESET_S: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
      CLEAR: begin
        idx_d = idx_q + LINE_AW'(1);
        if (idx_q == LINE_AW'(LINES - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RESET_S;
    endcase
  end

  assign wr_ok     = reset & (state_q == RUN);
  assign rd_zero   = (state_q != RUN);
  assign clear_we  = reset & (state_q == CLEAR);
  assign clear_idx = idx_q;
  assign busy      = (state_q == CLEAR);
`else
  assign wr_ok     = reset;
  assign rd_zero   = 1'b0;
  assign clear_we  = 1'b0;
  assign clear_idx = '0;
  assign busy      = 1'b0;
`endif

  // Port writes; the clear sequencer borrows the vector write path.
  logic               sc_we;
  logic               vec_we;
  logic               bank_vec_we;
  logic [LINE_AW-1:0] bank_vec_idx;
  line_t              bank_vec_data;

  assign sc_we         = MemWriteE & wr_ok;
  assign vec_we        = wren_b & wr_ok;
  assign bank_vec_we   = vec_we | clear_we;
  assign bank_vec_idx  = clear_we ? clear_idx : vec_line;
  assign bank_vec_data = clear_we ? '0 : data_b;

  line_t sc_rline;
  line_t vec_rline;

  dmem_bank #(
    .Lines  (LINES),
    .LineAw (LINE_AW)
  ) u_bank (
    .clk_i       (clk),
    .rst_ni      (reset),
    .vec_we_i    (bank_vec_we),
    .vec_widx_i  (bank_vec_idx),
    .vec_wdata_i (bank_vec_data),
    .sc_we_i     (sc_we),
    .sc_widx_i   (sc_line),
    .sc_lane_i   (sc_lane),
    .sc_wdata_i  (WriteDataE),
    .sc_ridx_i   (sc_line),
    .vec_ridx_i  (vec_line),
    .rd_zero_i   (rd_zero),
    .sc_rline_o  (sc_rline),
    .vec_rline_o (vec_rline)
  );

  // Collision flag and misalignment counter.
  logic       collision_q, collision_d;
  logic [7:0] cnt_q, cnt_d;
  logic       inc_s, inc_v;
  logic [9:0] cnt_sum;
  lane_t      sc_lane_q;

  always_comb begin
    collision_d = sc_we & vec_we & (sc_line == vec_line);
    inc_s       = sc_we & (ALUOutE[1:0] != 2'b00);
    inc_v       = vec_we & (address_b[3:0] != 4'h0);
    cnt_sum     = {2'b00, cnt_q} + {9'd0, inc_s} + {9'd0, inc_v};
    cnt_d       = (cnt_sum > 10'(SAT_MAX)) ? 8'(SAT_MAX) : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_q <= 1'b0;
      cnt_q       <= '0;
      sc_lane_q   <= '0;
    end else begin
      collision_q <= collision_d;
      cnt_q       <= cnt_d;
      sc_lane_q   <= sc_lane;
    end
  end

  assign ReadDataM    = sc_rline[int'(sc_lane_q)*WORD_W +: WORD_W];
  assign q_b          = vec_rline;
  assign collision    = collision_q;
  assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_dual_data_mem.sv
// Scoreboard bench for dual_data_mem (DEPTH_WORDS = 64, 16 lines). A word-array model
// computes expected outputs when each cycle's stimulus is driven; they are queued and
// popped after the clock edge for comparison.
module tb_dual_data_mem;

  logic         clk;
  logic         reset;
  logic         MemWriteE;
  logic [31:0]  ALUOutE;
  logic [31:0]  WriteDataE;
  logic [31:0]  ReadDataM;
  logic         wren_b;
  logic [31:0]  address_b;
  logic [127:0] data_b;
  logic [127:0] q_b;
  logic         collision;
  logic [7:0]   misalign_cnt;
  logic         busy;

  dual_data_mem #(
    .DEPTH_WORDS (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteE    (MemWriteE),
    .ALUOutE      (ALUOutE),
    .WriteDataE   (WriteDataE),
    .ReadDataM    (ReadDataM),
    .wren_b       (wren_b),
    .address_b    (address_b),
    .data_b       (data_b),
    .q_b          (q_b),
    .collision    (collision),
    .misalign_cnt (misalign_cnt),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [64];
  int          mcnt    = 0;
  int          clr_cnt = 0;

  logic [31:0]  exp_rd_q   [$];
  logic [127:0] exp_qb_q   [$];
  logic         exp_col_q  [$];
  logic [7:0]   exp_cnt_q  [$];
  logic         exp_busy_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) begin
      v[l*32 +: 32] = 32'hC000_0000 | 32'(i << 8) | 32'(l);
    end
    return v;
  endfunction

  // One clock cycle: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic ws, input logic [31:0] as, input logic [31:0] ds,
                      input logic wv, input logic [31:0] av, input logic [127:0] dv);
    logic         blocked;
    logic [127:0] eline;
    int           vb;
    MemWriteE  = ws;
    ALUOutE    = as;
    WriteDataE = ds;
    wren_b     = wv;
    address_b  = av;
    data_b     = dv;
    blocked = !reset || (clr_cnt != 0);
    vb      = int'(av[7:4]) * 4;
    exp_col_q.push_back(!blocked && ws && wv && (as[7:4] == av[7:4]));
    if (!blocked) begin
      if (wv) begin
        for (int l = 0; l < 4; l++) mdl[vb + l] = dv[l*32 +: 32];
      end
      if (ws) mdl[as[7:2]] = ds;
      if (ws && (as[1:0] != 2'b00)) mcnt++;
      if (wv && (av[3:0] != 4'h0)) mcnt++;
      if (mcnt > 255) mcnt = 255;
    end
    if (!reset) mcnt = 0;
    for (int l = 0; l < 4; l++) begin
      eline[l*32 +: 32] = blocked ? 32'h0 : mdl[vb + l];
    end
    exp_rd_q.push_back(blocked ? 32'h0 : mdl[as[7:2]]);
    exp_qb_q.push_back(eline);
    exp_cnt_q.push_back(8'(mcnt));
    if (reset && (clr_cnt != 0)) clr_cnt--;
    exp_busy_q.push_back(reset && (clr_cnt != 0));
    @(posedge clk);
    #1;
    check("ReadDataM", 128'(ReadDataM), 128'(exp_rd_q.pop_front()));
    check("q_b", q_b, exp_qb_q.pop_front());
    check("collision", 128'(collision), 128'(exp_col_q.pop_front()));
    check("misalign_cnt", 128'(misalign_cnt), 128'(exp_cnt_q.pop_front()));
    check("busy", 128'(busy), 128'(exp_busy_q.pop_front()));
  endtask

  task automatic idle(input logic [31:0] as, input logic [31:0] av);
    step(1'b0, as, 32'h0, 1'b0, av, 128'h0);
  endtask

  task automatic do_release();
    reset = 1'b1;
`ifdef DMEM_CLEAR_EN
    clr_cnt = 17;
    for (int w = 0; w < 64; w++) mdl[w] = 32'h0;
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_ReadDataM", 128'(ReadDataM), 128'h0);
    check("rst_q_b", q_b, 128'h0);
    check("rst_collision", 128'(collision), 128'h0);
    check("rst_misalign_cnt", 128'(misalign_cnt), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 64; w++) mdl[w] = 32'h0;
    reset      = 1'b0;
    MemWriteE  = 1'b0;
    ALUOutE    = 32'h0;
    WriteDataE = 32'h0;
    wren_b     = 1'b0;
    address_b  = 32'h0;
    data_b     = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    do_release();

`ifdef DMEM_CLEAR_EN
    // Writes during the clear are dropped; every line reads zero afterwards.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h12, {4{32'h5555_5555}});
    end
    for (int i = 0; i < 16; i++) idle(32'(i * 16), 32'(i * 16));
`endif

    // Give every line a known value.
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'(i * 16), pat(i));

    // Scalar write then read back on both ports.
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 128'h0);
    idle(32'h10, 32'h10);

    // Vector write then scalar lane read.
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20,
         128'h44444444_33333333_22222222_11111111);
    idle(32'h28, 32'h20);

    // Dual write to one line: scalar lane wins, collision pulses once.
    step(1'b1, 32'h34, 32'h1234_5678, 1'b1, 32'h30, {4{32'hAAAA_AAAA}});
    idle(32'h34, 32'h30);

    // Cross-port forwarding on the write edge.
    step(1'b0, 32'h44, 32'h0, 1'b1, 32'h40, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    step(1'b1, 32'h58, 32'hFEED_F00D, 1'b0, 32'h50, 128'h0);

    // Address wrap: upper bits ignored.
    step(1'b1, 32'h160, 32'h600D_CAFE, 1'b0, 32'h60, 128'h0);
    idle(32'h60, 32'h160);

    // Both ports misaligned in the same cycle.
    step(1'b1, 32'h71, 32'h7777_0001, 1'b1, 32'h82, pat(40));
    idle(32'h70, 32'h80);

    // Saturating misalign counter; data lands at word 0.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 32'h3, 32'(i), 1'b0, 32'h20, 128'h0);
    end
    idle(32'h0, 32'h0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h3, 32'(1000 + i), 1'b1, 32'h1, pat(50 + i));
    end
    reset = 1'b0;
    clr_cnt = 0;
    mcnt = 0;
    #1;
    check_reset_outputs();
    step(1'b1, 32'h10, 32'h0BAD_0BAD, 1'b1, 32'h10, {4{32'h0BAD_0BAD}});
    do_release();
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < 17; i++) idle(32'h0, 32'h0);
`endif
    idle(32'h10, 32'h20);
    idle(32'h0, 32'h0);
    idle(32'h34, 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
